// File: rtl/alu_operand_issue_pkg.sv
// Shared definitions for the ALU operand-issue stage: op_code values, instruction layout,
// and the reserved op_code check.
package alu_operand_issue_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_NOR = 4'd3,
    OP_ADD = 4'd5,
    OP_SUB = 4'd6,
    OP_SLT = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9,
    OP_SRA = 4'd10
  } alu_op_e;

  // Field order gives the bit positions: op[31:28] rd[27:23] rs[22:18] rt[17:13] imm_sel[12] imm12[11:0]
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        imm_sel;
    logic [11:0] imm12;
  } instr_t;

  function automatic logic is_reserved_op(input logic [3:0] op);
    return (op == 4'd4) || (op > 4'd10);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file, two read ports and one write port; r0 is hardwired to zero.
// Reads are combinational and see a same-cycle write to the addressed register.
module alu_regfile #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [4:0]   waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [4:0]   raddr_a_i,
  input  logic [4:0]   raddr_b_i,
  output logic [N-1:0] rdata_a_o,
  output logic [N-1:0] rdata_b_o
);

  logic [N-1:0] regs_q [32];
  logic         wr_live;

  assign wr_live = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == 5'd0)                      rdata_a_o = '0;
    else if (wr_live && waddr_i == raddr_a_i)   rdata_a_o = wdata_i;
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == 5'd0)                      rdata_b_o = '0;
    else if (wr_live && waddr_i == raddr_b_i)   rdata_b_o = wdata_i;
  end

endmodule

// File: rtl/alu_operand_issue.sv
// Operand-issue stage: one-deep output register fed from the register file, full throughput.
// Build option ALU_ISSUE_ILLEGAL_TRAP_EN: reserved op_codes are accepted and dropped instead of issued.
module alu_operand_issue
  import alu_operand_issue_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [N-1:0]     wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     X,
  output logic [N-1:0]     Y,
  output logic [3:0]       op_code,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] issued_count,
  output logic             illegal_flag
);

  instr_t     instr;
  logic [N-1:0] rs_val, rt_val, imm_ext;
  logic       accept, issue, handshake, reserved;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     x_q, x_d, y_q, y_d;
  logic [3:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  assign instr   = instr_t'(in_instr);
  assign imm_ext = {{(N-12){instr.imm12[11]}}, instr.imm12};

  alu_regfile #(.N(N)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (instr.rs),
    .raddr_b_i (instr.rt),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid_q & out_ready;
  assign reserved  = is_reserved_op(instr.op);

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign issue = accept & ~reserved;
`else
  assign issue = accept;
`endif

  // A reload in the same cycle as a handshake overrides the clear, keeping out_valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    op_d        = op_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    if (handshake) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CNT_W'(1);
    end
    if (issue) begin
      out_valid_d = 1'b1;
      x_d         = rs_val;
      y_d         = instr.imm_sel ? imm_ext : rt_val;
      op_d        = instr.op;
      rd_d        = instr.rd;
    end
    if (accept && reserved) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign X            = x_q;
  assign Y            = y_q;
  assign op_code      = op_q;
  assign out_rd       = rd_q;
  assign issued_count = cnt_q;
  assign illegal_flag = illegal_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: reference model with an expected-operation queue, a vector table,
// and directed stall / illegal / wrap / reset sequences.
module tb_alu_operand_issue;
  import alu_operand_issue_pkg::*;

  localparam int N     = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_instr = '0;
  logic             in_ready;
  logic             wb_en = 1'b0;
  logic [4:0]       wb_addr = '0;
  logic [N-1:0]     wb_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     X, Y;
  logic [3:0]       op_code;
  logic [4:0]       out_rd;
  logic [CNT_W-1:0] issued_count;
  logic             illegal_flag;

  always #5 clk = ~clk;

  alu_operand_issue #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .X            (X),
    .Y            (Y),
    .op_code      (op_code),
    .out_rd       (out_rd),
    .issued_count (issued_count),
    .illegal_flag (illegal_flag)
  );

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [3:0]   op;
    logic [4:0]   rd;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [4:0]   rd, rs, rt;
    logic         isel;
    logic [11:0]  imm;
    logic         wen;
    logic [4:0]   wa;
    logic [N-1:0] wd;
    logic [N-1:0] ex, ey;
  } vec_t;

  exp_t             sbq[$];
  vec_t             tbl[7];
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               quiet = 1'b0;
  logic             m_ov;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ill;
  logic [N-1:0]     m_regs[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic isel, input logic [11:0] imm);
    return {op, rd, rs, rt, isel, imm};
  endfunction

  function automatic logic [N-1:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    m_ov  = 1'b0;
    m_cnt = '0;
    m_ill = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    sbq.delete();
  endtask

  // One clock: evaluate handshake/accept on the current inputs, advance the model, check after the edge.
  task automatic step();
    logic acc, hs, rsv, iss;
    logic [11:0] imm;
    exp_t e, p;
    #1;
    acc = in_valid && (!m_ov || out_ready);
    hs  = m_ov && out_ready;
    rsv = (in_instr[31:28] == 4'd4) || (in_instr[31:28] > 4'd10);
    if (!quiet) begin
      chk("in_ready", in_ready, !m_ov || out_ready);
      chk("out_valid", out_valid, m_ov);
    end
    if (hs) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: got handshake, expected none queued");
      end else begin
        p = sbq.pop_front();
        if (!quiet) begin
          chk("sb_X", X, p.x);
          chk("sb_Y", Y, p.y);
          chk("sb_op", op_code, p.op);
          chk("sb_rd", out_rd, p.rd);
        end
      end
    end
    iss = acc;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    iss = acc && !rsv;
`endif
    if (iss) begin
      imm  = in_instr[11:0];
      e.x  = m_read(in_instr[22:18]);
      e.y  = in_instr[12] ? {{(N-12){imm[11]}}, imm} : m_read(in_instr[17:13]);
      e.op = in_instr[31:28];
      e.rd = in_instr[27:23];
      sbq.push_back(e);
    end
    m_ov = iss ? 1'b1 : (hs ? 1'b0 : m_ov);
    if (hs) m_cnt = m_cnt + 1'b1;
    if (acc && rsv) m_ill = 1'b1;
    if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    if (!quiet) begin
      chk("issued_count", issued_count, m_cnt);
      chk("illegal_flag", illegal_flag, m_ill);
    end
  endtask

  initial begin
    int guard;
    logic [CNT_W-1:0] cnt_before;

    tbl[0] = '{4'd5,  5'd5,  5'd3, 5'd4, 1'b0, 12'h000, 1'b0, 5'd0, 32'h0,        32'h7,        32'hFFFF_FFFE};
    tbl[1] = '{4'd6,  5'd1,  5'd3, 5'd0, 1'b1, 12'h800, 1'b0, 5'd0, 32'h0,        32'h7,        32'hFFFF_F800};
    tbl[2] = '{4'd0,  5'd2,  5'd4, 5'd3, 1'b0, 12'h000, 1'b0, 5'd0, 32'h0,        32'hFFFF_FFFE, 32'h7};
    tbl[3] = '{4'd1,  5'd7,  5'd6, 5'd0, 1'b0, 12'h000, 1'b1, 5'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0};
    tbl[4] = '{4'd2,  5'd8,  5'd0, 5'd0, 1'b0, 12'h000, 1'b1, 5'd0, 32'h1234_5678, 32'h0,        32'h0};
    tbl[5] = '{4'd5,  5'd9,  5'd0, 5'd0, 1'b1, 12'h7FF, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0000_07FF};
    tbl[6] = '{4'd10, 5'd31, 5'd6, 5'd6, 1'b0, 12'h000, 1'b0, 5'd0, 32'h0,        32'hA5A5_A5A5, 32'hA5A5_A5A5};

    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_X", X, 32'h0);
    chk("rst_Y", Y, 32'h0);
    chk("rst_op", op_code, 4'h0);
    chk("rst_rd", out_rd, 5'h0);
    chk("rst_count", issued_count, 16'h0);
    chk("rst_illegal", illegal_flag, 1'b0);
    rst_n = 1'b1;

    // Preload r3 and r4 through the write-back port
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0007;
    step();
    wb_addr = 5'd4; wb_data = 32'hFFFF_FFFE;
    step();
    wb_en = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = mk(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].isel, tbl[i].imm);
      wb_en = tbl[i].wen; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
      step();
      in_valid = 1'b0; wb_en = 1'b0;
      chk($sformatf("vec%0d_X", i), X, tbl[i].ex);
      chk($sformatf("vec%0d_Y", i), Y, tbl[i].ey);
      chk($sformatf("vec%0d_op", i), op_code, tbl[i].op);
      chk($sformatf("vec%0d_rd", i), out_rd, tbl[i].rd);
    end
    step();

    // Stall three cycles with a new instruction waiting, then release
    in_valid = 1'b1; in_instr = mk(4'd5, 5'd10, 5'd3, 5'd4, 1'b0, 12'h0);
    step();
    in_instr = mk(4'd6, 5'd11, 5'd4, 5'd3, 1'b0, 12'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_X", X, 32'h7);
      chk("stall_Y", Y, 32'hFFFF_FFFE);
      chk("stall_op", op_code, 4'd5);
      chk("stall_rd", out_rd, 5'd10);
    end
    cnt_before = m_cnt;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("release_count", issued_count, cnt_before + 1'b1);
    chk("release_out_valid", out_valid, 1'b1);
    chk("release_X", X, 32'hFFFF_FFFE);
    chk("release_Y", Y, 32'h7);
    chk("release_op", op_code, 4'd6);
    chk("release_rd", out_rd, 5'd11);
    step();

    // Reserved op_code 12
    in_valid = 1'b1; in_instr = mk(4'd12, 5'd12, 5'd3, 5'd4, 1'b0, 12'h0);
    step();
    in_valid = 1'b0;
    chk("illegal_set", illegal_flag, 1'b1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("trap_out_valid", out_valid, 1'b0);
`else
    chk("illegal_out_valid", out_valid, 1'b1);
    chk("illegal_op", op_code, 4'd12);
`endif
    step();
    in_valid = 1'b1; in_instr = mk(4'd0, 5'd1, 5'd3, 5'd4, 1'b0, 12'h0);
    step();
    in_valid = 1'b0;
    chk("illegal_sticky", illegal_flag, 1'b1);
    step();

    // Stream handshakes until the counter reaches its maximum, then wrap
    quiet = 1'b1;
    in_valid = 1'b1; in_instr = mk(4'd5, 5'd1, 5'd3, 5'd4, 1'b0, 12'h0);
    guard = 0;
    while (m_cnt != {CNT_W{1'b1}} && guard < 70000) begin
      step();
      guard++;
    end
    quiet = 1'b0;
    chk("wrap_guard", guard < 70000, 1'b1);
    chk("count_max", issued_count, 16'hFFFF);
    step();
    chk("count_wrap", issued_count, 16'h0000);
    in_valid = 1'b0;
    step();

    // Reset while an operation is stalled at the output
    in_valid = 1'b1; in_instr = mk(4'd7, 5'd3, 5'd4, 5'd3, 1'b0, 12'h0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("pre_reset_out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_X", X, 32'h0);
    chk("async_rst_Y", Y, 32'h0);
    chk("async_rst_op", op_code, 4'h0);
    chk("async_rst_rd", out_rd, 5'h0);
    chk("async_rst_count", issued_count, 16'h0);
    chk("async_rst_illegal", illegal_flag, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(4'd5, 5'd2, 5'd3, 5'd4, 1'b0, 12'h0);
    step();
    in_valid = 1'b0;
    chk("post_rst_r3_X", X, 32'h0);
    chk("post_rst_r4_Y", Y, 32'h0);
    step();
    chk("final_queue_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
